// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Decoupled instruction-fetch stage. It issues word-aligned fetch requests
// over a valid/ready memory interface and keeps up to DEPTH requests in
// flight. Returning instructions land in a DEPTH-entry ring that feeds decode.
// A redirect from the branch unit does three things:
//   - restarts fetch at the new PC,
//   - flushes the ring,
//   - counts the responses still outstanding so that they are discarded when
//     they arrive.
//
// Parameters
//   XLEN     : PC / address width
//   DEPTH    : ring entries (power of two, >= 2); also bounds queued +
//              in-flight + to-be-dropped requests
//   RESET_PC : first fetch address after reset
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   imem_req_*       : fetch request (valid/ready, word address)
//   imem_rsp_*       : in-order response; memory never back-pressures it
//   redirect_valid/pc: flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   id_valid/ready   : head instruction handshake towards decode
//   id_instr, id_pc  : head instruction word and its PC
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    // Architectural state
    logic [XLEN-1:0] fetch_pc_reg;
    logic [PW-1:0]   alloc_reg;
    logic [PW-1:0]   fill_reg;
    logic [PW-1:0]   read_reg;
    logic [PW-1:0]   drop_cnt_reg;
    // Keeps imem_req_valid low while in reset without routing rst_n
    // combinationally to an output. It rises on the first clock edge after
    // reset is released.
    logic            run_reg;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic [PW-1:0] used;
    logic [PW-1:0] inflight;
    logic [PW-1:0] occupancy;
    logic [PW-1:0] drop_on_redirect;
    logic [AW-1:0] alloc_idx;
    logic [AW-1:0] fill_idx;
    logic [AW-1:0] read_idx;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_drop;
    logic          rsp_accept;
    logic          id_fire;
    logic          unused_redirect_lsbs;

    // Occupancy never exceeds DEPTH, so PW-bit modular arithmetic is exact.
    assign used      = alloc_reg - read_reg;
    assign inflight  = alloc_reg - fill_reg;
    assign occupancy = used + drop_cnt_reg;

    assign alloc_idx = alloc_reg[AW-1:0];
    assign fill_idx  = fill_reg[AW-1:0];
    assign read_idx  = read_reg[AW-1:0];

    assign imem_req_valid = run_reg && (occupancy < DEPTH_P);
    assign imem_req_addr  = fetch_pc_reg;

    assign req_fire   = imem_req_valid && imem_req_ready;
    assign rsp_fire   = imem_rsp_valid;
    assign rsp_drop   = rsp_fire && (drop_cnt_reg != '0);
    assign rsp_accept = rsp_fire && (drop_cnt_reg == '0);

    assign id_valid = (fill_reg != read_reg);
    assign id_instr = instr_mem[read_idx];
    assign id_pc    = pc_mem[read_idx];
    assign id_fire  = id_valid && id_ready;

    // Count every response that is still owed by memory, so none of them
    // reaches the flushed queue. This covers:
    //   - responses already promised as drops (drop_cnt_reg),
    //   - live in-flight requests (inflight),
    //   - a request accepted in this cycle,
    // minus any response that arrives in this cycle.
    assign drop_on_redirect = drop_cnt_reg + inflight
                            + (req_fire ? ONE_P : '0)
                            - (rsp_fire ? ONE_P : '0);

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Pointer, drop counter and fetch PC state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_reg <= RESET_PC;
            alloc_reg    <= '0;
            fill_reg     <= '0;
            read_reg     <= '0;
            drop_cnt_reg <= '0;
            run_reg      <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (redirect_valid) begin
                fetch_pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
                alloc_reg    <= '0;
                fill_reg     <= '0;
                read_reg     <= '0;
                drop_cnt_reg <= drop_on_redirect;
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                    alloc_reg    <= alloc_reg + ONE_P;
                end
                if (rsp_accept) begin
                    fill_reg <= fill_reg + ONE_P;
                end
                if (rsp_drop) begin
                    drop_cnt_reg <= drop_cnt_reg - ONE_P;
                end
                if (id_fire) begin
                    read_reg <= read_reg + ONE_P;
                end
            end
        end
    end

    // Entry storage. Writes during a redirect cycle are harmless because the
    // pointers are realigned in the same cycle, so those entries are never
    // read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else begin
            if (req_fire) begin
                pc_mem[alloc_idx] <= fetch_pc_reg;
            end
            if (rsp_accept) begin
                instr_mem[fill_idx] <= imem_rsp_data;
            end
        end
    end

    // A response needs either a live request or an expected drop behind it.
    a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (drop_cnt_reg != '0 || inflight != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit (XLEN=32, DEPTH=4, RESET_PC=0).
//
// Memory model: a queue of accepted request addresses. When it is enabled,
// it answers one cycle after acceptance with instr_of(addr). Every
// instruction that decode consumes is logged, and the logs are compared
// against the expected PC / instruction sequences.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            id_valid;
    logic            id_ready = 1'b0;
    logic [31:0]     id_instr;
    logic [XLEN-1:0] id_pc;

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mem_en   = 1'b0;

    logic [31:0] pend_q[$];
    logic [31:0] req_log[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One clock cycle. This runs at posedge+1: outputs are settled, inputs
    // are driven for the cycle, and the cycle's handshakes are recorded.
    task automatic cycle(input bit rdy, input bit idr, input bit redir = 1'b0,
                         input logic [31:0] rpc = 32'h0);
        imem_req_ready = rdy;
        id_ready       = idr;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mem_en && pend_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        if (imem_req_valid && rdy) begin
            pend_q.push_back(imem_req_addr);
            req_log.push_back(imem_req_addr);
            $display("req  addr=%h", imem_req_addr);
        end
        if (id_valid && idr) begin
            got_pc.push_back(id_pc);
            got_instr.push_back(id_instr);
            $display("id   pc=%h instr=%h", id_pc, id_instr);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mem_en         = 1'b0;
        pend_q.delete();
        req_log.delete();
        got_pc.delete();
        got_instr.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- Reset values and release -----------------------------------
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("rst_id_valid",  32'(id_valid),       32'h0);
        check("rst_id_instr",  id_instr,            32'h0);
        check("rst_id_pc",     id_pc,               32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_req_valid", 32'(imem_req_valid), 32'h1);
        check("rel_req_addr",  imem_req_addr,       32'h0);

        // ---- Streaming: 1-cycle memory, decode always ready --------------
        mem_en = 1'b1;
        for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stream_req%0d", k),   req_log[k],   32'(4 * k));
            check($sformatf("stream_pc%0d", k),    got_pc[k],    32'(4 * k));
            check($sformatf("stream_instr%0d", k), got_instr[k], instr_of(32'(4 * k)));
        end
        // The first consume happens in cycle 2, then one per cycle.
        check("stream_throughput", 32'(got_pc.size()), 32'd10);

        // ---- Queue fills while decode stalls -----------------------------
        do_reset();
        mem_en = 1'b1;
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b0);
        check("full_req_count", 32'(req_log.size()), 32'd4);
        check("full_req_valid", 32'(imem_req_valid),  32'h0);
        check("full_id_pc",     id_pc,                32'h0);
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            check($sformatf("drain_pc%0d", k), got_pc[k], 32'(4 * k));
        check("resume_req_addr", req_log[4], 32'h10);
        check("resume_pc",       got_pc[4],  32'h10);

        // ---- Redirect with 3 in flight plus a request in the same cycle --
        do_reset();
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 32'h103);
        check("redir_req_count", 32'(req_log.size()), 32'd4);
        check("redir_req_addr",  imem_req_addr,       32'h100);
        check("redir_req_valid", 32'(imem_req_valid), 32'h0);
        check("redir_id_valid",  32'(id_valid),       32'h0);
        mem_en = 1'b1;
        for (int c = 0; c < 12; c++) cycle(1'b1, 1'b1);
        check("redir_first_pc",    got_pc[0],    32'h100);
        check("redir_first_instr", got_instr[0], instr_of(32'h100));
        check("redir_second_pc",   got_pc[1],    32'h104);

        // ---- Redirect together with a response and an id_fire ------------
        do_reset();
        mem_en = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("rri_id_valid", 32'(id_valid), 32'h1);
        cycle(1'b1, 1'b1, 1'b1, 32'h200);
        check("rri_id_valid_after", 32'(id_valid),    32'h0);
        check("rri_req_addr",       imem_req_addr,    32'h200);
        for (int c = 0; c < 8; c++) cycle(1'b1, 1'b1);
        check("rri_consumed0",    got_pc[0],    32'h0);
        check("rri_consumed1",    got_pc[1],    32'h200);
        check("rri_instr1",       got_instr[1], instr_of(32'h200));

        // ---- Reset mid-stream: 2 queued, 2 in flight ---------------------
        do_reset();
        mem_en = 1'b1;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        mem_en = 1'b0;
        cycle(1'b1, 1'b0);
        check("mid_id_valid_pre", 32'(id_valid),       32'h1);
        check("mid_pend_pre",     32'(pend_q.size()),  32'd2);
        rst_n = 1'b0;
        pend_q.delete();
        #1;
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
        check("mid_rst_id_valid",  32'(id_valid),       32'h0);
        check("mid_rst_id_instr",  id_instr,            32'h0);
        check("mid_rst_id_pc",     id_pc,               32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_req_valid", 32'(imem_req_valid), 32'h1);
        check("mid_rel_req_addr",  imem_req_addr,       32'h0);

        // ---- Fetch PC wraps at the top of the address space --------------
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0);
        check("wrap_addr_zero", imem_req_addr, 32'h0);
        mem_en = 1'b1;
        for (int c = 0; c < 5; c++) cycle(1'b1, 1'b1);
        check("wrap_pc0", got_pc[0], 32'hFFFF_FFFC);
        check("wrap_pc1", got_pc[1], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
